// File: rtl/seq_chunk_adder_if.sv
// Operand/result bundle for seq_chunk_adder: operand side and result side, each valid/ready.
// Latency: none (wires only).
// Backpressure: in_ready gates the producer, out_ready holds the result in place.
//
// Signals:
//   in_valid/in_ready   operand handshake (producer -> adder)
//   a, b, sub           operands and mode (0 = a+b, 1 = a-b)
//   out_valid/out_ready result handshake (adder -> consumer)
//   s                   {carry_out, sum[WIDTH-1:0]}
//   ovf                 two's-complement overflow of sum
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   s;
    logic             ovf;

    // The adder side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, ovf
    );

    // The producer/consumer side.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds a WIDTH-bit pair CHUNK bits per clock with a registered carry.
// Latency: accept at posedge T, out_valid after posedge T+N (N = WIDTH/CHUNK); one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result and ovf held stable in DONE until out_ready.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any operation in flight
//   bus    seq_chunk_adder_if.slave (operand and result handshakes, s, ovf)
//
// WIDTH must be an integer multiple of CHUNK; CHUNK == WIDTH gives a single BUSY cycle.
module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_chunk_adder_if.slave bus
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // holds ~b for subtract, so BUSY always adds
    logic             carry_q;  // seeded with sub: the +1 of the two's complement
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] sum_q;    // working sum, separate from s so s keeps the last result
    logic [WIDTH:0]   s_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] sum_next;
    logic             msb_cin;
    logic             last_chunk;

    // Datapath for the chunk selected by idx_q.
    always_comb begin
        a_chunk    = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_chunk    = b_q[int'(idx_q) * CHUNK +: CHUNK];
        chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        sum_next   = sum_q;
        sum_next[int'(idx_q) * CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
        msb_cin    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_next[WIDTH-1];
        last_chunk = (idx_q == IDXW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            s_q         <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        carry_q    <= bus.sub;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end

                BUSY: begin
                    sum_q   <= sum_next;
                    carry_q <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        s_q         <= {chunk_res[CHUNK], sum_next};
                        ovf_q       <= msb_cin ^ chunk_res[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: directed corner cases on WIDTH=16/CHUNK=4 and
// randomized regressions on 16/4, 8/1 and 32/32 against an arithmetic reference model.
// Stimulus is driven #1 after posedge or at negedge; outputs are sampled #1 after posedge.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) if16 ();
    seq_chunk_adder_if #(.WIDTH(8))  if8  ();
    seq_chunk_adder_if #(.WIDTH(32)) if32 ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
    seq_chunk_adder #(.WIDTH(8),  .CHUNK(1))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

    int checks = 0;
    int errors = 0;

    // cfg 0: 16/4, cfg 1: 8/1, cfg 2: 32/32
    function automatic int width_of(input int cfg);
        case (cfg)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int ncycles_of(input int cfg);
        case (cfg)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference: unsigned arithmetic for the sum and carry/borrow,
    // signed arithmetic range check for overflow.
    function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic sv, output logic [63:0] es, output logic eo);
        logic [63:0] mask;
        logic [63:0] ua, ub, low;
        logic        c;
        longint      sa, sb, r, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        ua   = av & mask;
        ub   = bv & mask;
        if (sv) begin
            low = (ua - ub) & mask;
            c   = (ua >= ub);
        end else begin
            low = (ua + ub) & mask;
            c   = ((ua + ub) >> w) != 64'd0;
        end
        es   = ({63'd0, c} << w) | low;
        sa   = ua[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        r    = sv ? sa - sb : sa + sb;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        eo   = (r > smax) || (r < smin);
    endfunction

    task automatic drive(input int cfg, input logic v, input logic [63:0] av,
                         input logic [63:0] bv, input logic sv, input logic ordy);
        case (cfg)
            0: begin
                if16.in_valid = v; if16.a = av[15:0]; if16.b = bv[15:0];
                if16.sub = sv; if16.out_ready = ordy;
            end
            1: begin
                if8.in_valid = v; if8.a = av[7:0]; if8.b = bv[7:0];
                if8.sub = sv; if8.out_ready = ordy;
            end
            default: begin
                if32.in_valid = v; if32.a = av[31:0]; if32.b = bv[31:0];
                if32.sub = sv; if32.out_ready = ordy;
            end
        endcase
    endtask

    task automatic sample(input int cfg, output logic ov, output logic ir,
                          output logic [63:0] so, output logic oo);
        case (cfg)
            0: begin
                ov = if16.out_valid; ir = if16.in_ready; so = 64'(if16.s); oo = if16.ovf;
            end
            1: begin
                ov = if8.out_valid; ir = if8.in_ready; so = 64'(if8.s); oo = if8.ovf;
            end
            default: begin
                ov = if32.out_valid; ir = if32.in_ready; so = 64'(if32.s); oo = if32.ovf;
            end
        endcase
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full operation with out_ready held high. Returns result and the number
    // of posedges from accept to out_valid; returns after the consuming edge.
    task automatic do_op(input int cfg, input logic [63:0] av, input logic [63:0] bv,
                         input logic sv, output logic [63:0] so, output logic oo,
                         output int lat);
        logic ov, ir;
        @(negedge clk);
        drive(cfg, 1'b1, av, bv, sv, 1'b1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the result must not depend on them.
        drive(cfg, 1'b0, rnd64(), rnd64(), 1'($urandom), 1'b1);
        lat = 0;
        ov  = 1'b0;
        so  = '0;
        oo  = 1'b0;
        while (!ov && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            sample(cfg, ov, ir, so, oo);
        end
        checks++;
        if (!ov) begin
            errors++;
            $display("FAIL do_op_timeout cfg=%0d: out_valid=%0b after %0d cycles, required 1", cfg, ov, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic ov, ir, oo;
        logic [63:0] so;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) drive(c, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        #12;
        for (int c = 0; c < 3; c++) begin
            sample(c, ov, ir, so, oo);
            checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready cfg=%0d: got %b want 1", c, ir); end
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid cfg=%0d: got %b want 0", c, ov); end
            checks++; if (so !== 64'd0) begin errors++; $display("FAIL reset_s cfg=%0d: got %h want 0", c, so); end
            checks++; if (oo !== 1'b0) begin errors++; $display("FAIL reset_ovf cfg=%0d: got %b want 0", c, oo); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_carry_wrap();
        logic [63:0] so, s2;
        logic oo, o2, ov, ir;
        int lat;
        do_op(0, 64'hFFFF, 64'h0001, 1'b0, so, oo, lat);
        checks++; if (so !== 64'h10000) begin errors++; $display("FAIL carry_wrap_s: got %h want 10000", so); end
        checks++; if (oo !== 1'b0) begin errors++; $display("FAIL carry_wrap_ovf: got %b want 0", oo); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL carry_wrap_latency: got %0d want 4", lat); end
        // out_valid is a single-cycle pulse when the consumer is ready.
        sample(0, ov, ir, s2, o2);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL carry_wrap_pulse: out_valid got %b want 0", ov); end
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL carry_wrap_idle: in_ready got %b want 1", ir); end
        // Result is retained in IDLE.
        checks++; if (s2 !== 64'h10000) begin errors++; $display("FAIL carry_wrap_hold: s got %h want 10000", s2); end
    endtask

    task automatic test_sub_ovf();
        logic [15:0] ta [4] = '{16'h0005, 16'h8000, 16'h7FFF, 16'h8000};
        logic [15:0] tb [4] = '{16'h0007, 16'h0001, 16'h0001, 16'h8000};
        logic        ts [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [16:0] te [4] = '{17'h0FFFE, 17'h17FFF, 17'h08000, 17'h10000};
        logic        to [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] so;
        logic oo;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(0, 64'(ta[i]), 64'(tb[i]), ts[i], so, oo, lat);
            checks++;
            if (so !== 64'(te[i])) begin errors++; $display("FAIL sub_ovf_s[%0d]: got %h want %h", i, so, te[i]); end
            checks++;
            if (oo !== to[i]) begin errors++; $display("FAIL sub_ovf_ovf[%0d]: got %b want %b", i, oo, to[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic ov, ir, oo;
        logic [63:0] so;
        int n;
        @(negedge clk);
        drive(0, 1'b1, 64'h1234, 64'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        n  = 0;
        ov = 1'b0;
        while (!ov && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            sample(0, ov, ir, so, oo);
        end
        checks++;
        if (!ov) begin errors++; $display("FAIL bp_wait: out_valid got %b want 1", ov); end
        // Three stalled cycles with new operands offered.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 1'b1, rnd64(), rnd64(), 1'($urandom), 1'b0);
            @(posedge clk);
            #1;
            sample(0, ov, ir, so, oo);
            checks++; if (ov !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, ov); end
            checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, ir); end
            checks++; if (so !== 64'h02345) begin errors++; $display("FAIL bp_s[%0d]: got %h want 02345", k, so); end
            checks++; if (oo !== 1'b0) begin errors++; $display("FAIL bp_ovf[%0d]: got %b want 0", k, oo); end
        end
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        sample(0, ov, ir, so, oo);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL bp_consume: out_valid got %b want 0", ov); end
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL bp_no_capture: in_ready got %b want 1", ir); end
    endtask

    task automatic test_reset_mid_busy();
        logic ov, ir, oo, seen;
        logic [63:0] so;
        int lat;
        @(negedge clk);
        drive(0, 1'b1, 64'h00FF, 64'h0F01, 1'b0, 1'b1);
        @(posedge clk);          // accept
        #1;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1);
        @(posedge clk);          // end of first BUSY cycle
        #1;
        rst_n = 1'b0;
        #1;
        sample(0, ov, ir, so, oo);
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rst_busy_out_valid: got %b want 0", ov); end
        checks++; if (ir !== 1'b1) begin errors++; $display("FAIL rst_busy_in_ready: got %b want 1", ir); end
        checks++; if (so !== 64'd0) begin errors++; $display("FAIL rst_busy_s: got %h want 0", so); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            sample(0, ov, ir, so, oo);
            if (ov) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_busy_ghost: out_valid seen %b want 0", seen); end
        do_op(0, 64'h00FF, 64'h0F01, 1'b0, so, oo, lat);
        checks++; if (so !== 64'h01000) begin errors++; $display("FAIL rst_busy_next_s: got %h want 01000", so); end
        checks++; if (oo !== 1'b0) begin errors++; $display("FAIL rst_busy_next_ovf: got %b want 0", oo); end
    endtask

    task automatic test_random();
        logic [63:0] av, bv, so, es;
        logic sv, oo, eo;
        int lat, w, nerr, e0;
        for (int c = 0; c < 3; c++) begin
            w    = width_of(c);
            e0   = errors;
            for (int i = 0; i < 150; i++) begin
                av = rnd64();
                bv = rnd64();
                sv = 1'($urandom);
                model(w, av, bv, sv, es, eo);
                do_op(c, av, bv, sv, so, oo, lat);
                checks++;
                if (so !== es) begin
                    errors++;
                    $display("FAIL rand_s cfg=%0d vec=%0d a=%h b=%h sub=%b: got %h want %h", c, i, av, bv, sv, so, es);
                end
                checks++;
                if (oo !== eo) begin
                    errors++;
                    $display("FAIL rand_ovf cfg=%0d vec=%0d a=%h b=%h sub=%b: got %b want %b", c, i, av, bv, sv, oo, eo);
                end
                checks++;
                if (lat !== ncycles_of(c)) begin
                    errors++;
                    $display("FAIL rand_latency cfg=%0d vec=%0d: got %0d want %0d", c, i, lat, ncycles_of(c));
                end
            end
            nerr = errors - e0;
            $display("random WIDTH=%0d: 150 vectors, %0d errors", w, nerr);
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_sub_ovf();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the 4-bit combinational ripple-carry adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, carrying the inter-chunk carry in a register.
- Adds add/subtract mode, signed-overflow detection and valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer; the random-vector bench compares it against a behavioural a+b / a-b model.

Parameters:
- WIDTH, 16, operand width in bits; WIDTH must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; N = WIDTH/CHUNK is the number of compute cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode valid
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A-B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  WIDTH+1  {carry_out, sum[WIDTH-1:0]}
- ovf  output  1  two's-complement signed overflow of sum[WIDTH-1:0]

Behaviour:
- Reset, asynchronous on rst_n low, drives:
  - FSM to IDLE, in_ready=1, out_valid=0, s=0, ovf=0.
  - Operand, chunk-index and carry registers to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On posedge with in_valid=1: latch a, latch b (inverted if sub=1), latch sub.
  - Set carry register to sub (1 for subtract, 0 for add), clear chunk index, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle adds chunk k of A and chunk k of B' plus the carry register.
  - Writes the CHUNK-bit result into sum bits [k*CHUNK +: CHUNK] and updates the carry register.
  - After chunk N-1: s[WIDTH] = final carry, ovf = carry into MSB XOR carry out of MSB; go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - s and ovf are held stable while out_ready=0.
  - On posedge with out_ready=1, go to IDLE and drop out_valid.
- Latency:
  - Operands accepted at posedge T; out_valid goes high after posedge T+N.
  - Earliest next accept is the posedge after the output handshake. Throughput is one operation per N+2 cycles with no back-pressure.
- N=1 (CHUNK=WIDTH) is legal: a single BUSY cycle.
- Subtract semantics:
  - s[WIDTH]=1 means no borrow (A >= B unsigned); s[WIDTH]=0 means borrow.
  - sum is A-B mod 2^WIDTH.
- in_valid while not in IDLE is ignored; operands are not captured and no error is raised.
- a, b and sub may change freely after acceptance without affecting the result.
- s and ovf keep the last result after returning to IDLE, until overwritten at the end of the next BUSY.
- Reset asserted mid-BUSY or mid-DONE: the operation is discarded, reset values apply immediately, and no out_valid is produced for it.
- Carry wrap: 0xFFFF+0x0001 style inputs must propagate the carry across every chunk boundary.

Test Plan:
- WIDTH=16, CHUNK=4, add 0xFFFF+0x0001, out_ready=1 -> s=0x10000, ovf=0; out_valid high exactly after the 4th posedge following accept, for one cycle.
- Subtract 0x0005-0x0007 -> s=0x0FFFE (s[16]=0, borrow), ovf=0; subtract 0x8000-0x0001 -> s=0x17FFF, ovf=1.
- Add 0x7FFF+0x0001 -> s=0x08000, ovf=1; add 0x8000+0x8000 -> s=0x10000, ovf=1.
- Back-pressure: hold out_ready=0 for 3 cycles after out_valid, with in_valid=1 and new operands -> s, ovf and out_valid stable, in_ready=0, no new capture; result consumed on the first cycle out_ready=1.
- Assert rst_n=0 during the 2nd BUSY cycle -> out_valid=0, s=0 and in_ready=1 immediately; after release the next operation completes correctly.
- Random regression: 150 random a/b/sub vectors, each at WIDTH=16/CHUNK=4, WIDTH=8/CHUNK=1 and WIDTH=32/CHUNK=32 -> zero mismatches against the behavioural model on s and ovf; error count and vector count are reported.
